// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_sequencer_pkg;

    // Width of the shift-cycle down-counter.
    localparam int unsigned CNT_W = 3;

    // Shift-register mode select, driven as {s1, s0}.
    typedef enum logic [1:0] {
        ModeHold = 2'b00,
        ModeLoad = 2'b01,
        ModeShr  = 2'b10,  // toward Q0, shr_in enters Q3
        ModeShl  = 2'b11   // toward Q3, shl_in enters Q0
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/shift_count.sv
// Loadable down-counter with zero flag.
// Priority: clear, then load, then decrement. Decrement saturates at zero.
module shift_count import shift_sequencer_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer driving a 4-bit universal shift register: load, shift N times, pulse done.
// Optional feature: define SEQ_ROTATE_EN to feed the register's own end bit back
// as the serial input when the command's rot bit is set.
module shift_sequencer import shift_sequencer_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [3:0]       data_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             dir_i,
    input  logic             fill_i,
    input  logic             rot_i,
    input  logic [3:0]       q_i,
    output logic             s1_o,
    output logic             s0_o,
    output logic [3:0]       i_o,
    output logic             shr_in_o,
    output logic             shl_in_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    mode_e            mode;
    logic [3:0]       data_q, data_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             serial;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_one;
    logic             accept;
    logic             abort_act;

    // Start is only honoured in idle; abort only cancels an active command.
    assign accept    = (state_q == StIdle) && start_i;
    assign abort_act = abort_i && ((state_q == StLoad) || (state_q == StShift));
    assign cnt_one   = (cnt == CNT_W'(1));

    shift_count u_shift_count (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (abort_act),
        .load_i     (accept),
        .load_val_i (count_i),
        .dec_i      (state_q == StShift),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // Command parameters captured on an accepted start.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        fill_d = fill_q;
        if (accept) begin
            data_d = data_i;
            dir_d  = dir_i;
            fill_d = fill_i;
        end
    end

    // Parameter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQ_ROTATE_EN
    logic rot_q, rot_d;

    // Rotate request captured alongside the other parameters.
    always_comb begin
        rot_d = accept ? rot_i : rot_q;
    end

    // Rotate register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end

    // Rotation recirculates the bit leaving the register at the far end.
    assign serial = rot_q ? (dir_q ? q_i[3] : q_i[0]) : fill_q;
`else
    logic unused_rot;
    assign unused_rot = ^{rot_i, q_i};
    assign serial     = fill_q;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the counter holds N..1 during shift.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StLoad;
            StLoad: begin
                if (abort_i)       state_d = StIdle;
                else if (cnt_zero) state_d = StDone;
                else               state_d = StShift;
            end
            StShift: begin
                if (abort_i)      state_d = StIdle;
                else if (cnt_one) state_d = StDone;
            end
            StDone:  state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        mode   = ModeHold;
        busy_o = 1'b1;
        done_o = 1'b0;
        unique case (state_q)
            StIdle:  busy_o = 1'b0;
            StLoad:  mode   = ModeLoad;
            StShift: mode   = dir_q ? ModeShl : ModeShr;
            StDone:  done_o = 1'b1;
        endcase
    end

    assign {s1_o, s0_o} = mode;
    assign i_o          = data_q;
    assign shr_in_o     = serial;
    assign shl_in_o     = serial;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: an external 4-bit universal shift register closes the loop,
// commands push expected results into a scoreboard, a monitor checks them on done.
module tb_shift_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [3:0] data_i = 4'h0;
    logic [2:0] count_i = 3'd0;
    logic       dir_i = 1'b0;
    logic       fill_i = 1'b0;
    logic       rot_i = 1'b0;
    logic [3:0] sr_q = 4'h0;
    logic       s1_o, s0_o, shr_in_o, shl_in_o, busy_o, done_o;
    logic [3:0] i_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] data;
        int         cnt;
        logic [1:0] mode;
        logic [3:0] q;
    } exp_t;

    exp_t sb[$];

    shift_sequencer dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .data_i   (data_i),
        .count_i  (count_i),
        .dir_i    (dir_i),
        .fill_i   (fill_i),
        .rot_i    (rot_i),
        .q_i      (sr_q),
        .s1_o     (s1_o),
        .s0_o     (s0_o),
        .i_o      (i_o),
        .shr_in_o (shr_in_o),
        .shl_in_o (shl_in_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural universal shift register driven by the sequencer.
    always @(posedge clk_i) begin
        case ({s1_o, s0_o})
            2'b01:   sr_q <= i_o;
            2'b10:   sr_q <= {shr_in_o, sr_q[3:1]};
            2'b11:   sr_q <= {sr_q[2:0], shl_in_o};
            default: sr_q <= sr_q;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: tallies the cycles of each command and checks against the scoreboard on done.
    initial begin
        int         busy_n;
        int         load_n;
        int         shift_n;
        logic [1:0] shm;
        logic [3:0] ival;
        exp_t       e;
        busy_n = 0; load_n = 0; shift_n = 0; shm = 2'b00; ival = 4'h0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && busy_o) begin
                busy_n++;
                if ({s1_o, s0_o} == 2'b01) begin
                    load_n++;
                    ival = i_o;
                end
                if (s1_o) begin
                    shift_n++;
                    shm = {s1_o, s0_o};
                end
                if (done_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done_o), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("load_cycles", 32'(load_n), 32'd1);
                        check("load_value", 32'(ival), 32'(e.data));
                        check("shift_cycles", 32'(shift_n), 32'(e.cnt));
                        check("done_latency", 32'(busy_n), 32'(e.cnt + 2));
                        check("done_mode", 32'({s1_o, s0_o}), 32'd0);
                        if (e.cnt > 0) check("shift_mode", 32'(shm), 32'(e.mode));
                        check("final_q", 32'(sr_q), 32'(e.q));
                    end
                end
            end else begin
                busy_n = 0; load_n = 0; shift_n = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_o; i++) @(negedge clk_i);
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic issue(input logic [3:0] d, input logic [2:0] c, input logic dr,
                         input logic fl, input logic rt, input logic ab, input logic [3:0] qx);
        @(negedge clk_i);
        data_i = d; count_i = c; dir_i = dr; fill_i = fl; rot_i = rt; abort_i = ab;
        start_i = 1'b1;
        sb.push_back('{data: d, cnt: int'(c), mode: (dr ? 2'b11 : 2'b10), q: qx});
        @(negedge clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int dones;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", 32'({s1_o, s0_o, i_o, shr_in_o, shl_in_o, busy_o, done_o}), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_outputs", 32'({s1_o, s0_o, i_o, busy_o, done_o}), 32'd0);

        // Shift toward Q3 three times with zero fill.
        issue(4'b1011, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000);
        // Count zero: load straight to done.
        issue(4'b0110, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
        // Ones shifted in toward Q0.
        issue(4'b0000, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100);
        // Maximum count, ones toward Q3.
        issue(4'b0101, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
        // Start and abort together in idle: start wins.
        issue(4'b1100, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1110);
`ifdef SEQ_ROTATE_EN
        issue(4'b1001, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001);
        issue(4'b1010, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101);
`else
        issue(4'b1001, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        issue(4'b1010, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
`endif

        // Abort during the second shift cycle.
        @(negedge clk_i);
        data_i = 4'b1111; count_i = 3'd5; dir_i = 1'b0; fill_i = 1'b0; rot_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("abort_in_shift", 32'({s1_o, s0_o}), 32'b10);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_mode", 32'({s1_o, s0_o}), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        dones = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // Start held high: parameter changes during the first command must not leak in.
        @(negedge clk_i);
        data_i = 4'b0011; count_i = 3'd2; dir_i = 1'b1; fill_i = 1'b1; rot_i = 1'b0;
        start_i = 1'b1;
        sb.push_back('{data: 4'b0011, cnt: 2, mode: 2'b11, q: 4'b1111});
        @(negedge clk_i);
        data_i = 4'b1000; count_i = 3'd2; dir_i = 1'b0; fill_i = 1'b0;
        sb.push_back('{data: 4'b1000, cnt: 2, mode: 2'b10, q: 4'b0010});
        wait_idle();
        @(negedge clk_i);
        check("restart_busy", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a shift.
        @(negedge clk_i);
        data_i = 4'b1111; count_i = 3'd6; dir_i = 1'b0; fill_i = 1'b1; rot_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("pre_reset_busy", 32'({busy_o, shr_in_o}), 32'b11);
        #2 rst_ni = 1'b0;
        #1 check("async_reset_outputs",
                 32'({s1_o, s0_o, i_o, shr_in_o, shl_in_o, busy_o, done_o}), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
        check("post_reset_idle", 32'({busy_o, s1_o, s0_o}), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
